// File: rtl/pe_loop_cntl.sv
// rtl/pe_loop_cntl.sv - per-PE loop-nest controller: layer -> k -> c -> a -> w sequencing
// Requests filter/input streams, issues coordinates under back-pressure, drains, hands off to PPU.
module pe_loop_cntl #(
  parameter int NUM_LAYERS = 4,
  parameter int MAX_K      = 64,
  parameter int MAX_C      = 64,
  parameter int MAX_A      = 256,
  parameter int MAX_W      = 256,
  parameter int I_STEP     = 4,
  parameter int F_STEP     = 4,
  parameter int PIPE_DEPTH = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_LAYERS)-1:0]   cfg_layer,
  input  logic [$clog2(MAX_K):0]          cfg_k_cnt,
  input  logic [$clog2(MAX_C):0]          cfg_c_cnt,
  input  logic [$clog2(MAX_A):0]          cfg_a_cnt,
  input  logic [$clog2(MAX_W):0]          cfg_w_cnt,
  input  logic                            cfg_sparse,
  input  logic [$clog2(NUM_LAYERS):0]     num_layers,
  input  logic                            start,
  output logic [$clog2(MAX_C)-1:0]        cur_c,
  input  logic [$clog2(MAX_A):0]          nz_cnt,
  output logic                            req_filter_valid,
  output logic                            req_input_valid,
  output logic [$clog2(MAX_K)-1:0]        req_k,
  output logic [$clog2(NUM_LAYERS)-1:0]   req_layer,
  input  logic                            filter_done,
  input  logic                            input_done,
  output logic                            issue_valid,
  input  logic                            issue_ready,
  output logic [$clog2(MAX_K)-1:0]        issue_k,
  output logic [$clog2(MAX_C)-1:0]        issue_c,
  output logic [$clog2(MAX_A)-1:0]        issue_a,
  output logic [$clog2(MAX_W)-1:0]        issue_w,
  output logic                            issue_last,
  output logic                            ppu_start,
  input  logic                            ppu_done,
  output logic                            busy,
  output logic                            done
);
  localparam int LW = $clog2(NUM_LAYERS);
  localparam int KW = $clog2(MAX_K);
  localparam int CW = $clog2(MAX_C);
  localparam int AW = $clog2(MAX_A);
  localparam int WW = $clog2(MAX_W);
  localparam int DW = $clog2(PIPE_DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_EXEC, S_DRAIN, S_PPU} state_t;

  state_t          r_state, w_state_nxt;
  logic [LW-1:0]   r_layer, w_layer_nxt;
  logic [KW-1:0]   r_k, w_k_nxt;
  logic [CW-1:0]   r_c, w_c_nxt;
  logic [AW-1:0]   r_a, w_a_nxt;
  logic [WW-1:0]   r_w, w_w_nxt;
  logic [LW:0]     r_num_layers, w_nl_nxt;
  logic            r_fdone, w_fdone_nxt;
  logic            r_idone, w_idone_nxt;
  logic [DW-1:0]   r_drain, w_drain_nxt;

  // Layer table has no reset so a mid-run reset keeps the programmed layers.
  logic [KW:0]     r_cfg_k [NUM_LAYERS];
  logic [CW:0]     r_cfg_c [NUM_LAYERS];
  logic [AW:0]     r_cfg_a [NUM_LAYERS];
  logic [WW:0]     r_cfg_w [NUM_LAYERS];
  logic            r_cfg_sp [NUM_LAYERS];

  always_ff @(posedge clk) begin
    if (cfg_we && r_state == S_IDLE) begin
      r_cfg_k[cfg_layer]  <= cfg_k_cnt;
      r_cfg_c[cfg_layer]  <= cfg_c_cnt;
      r_cfg_a[cfg_layer]  <= cfg_a_cnt;
      r_cfg_w[cfg_layer]  <= cfg_w_cnt;
      r_cfg_sp[cfg_layer] <= cfg_sparse;
    end
  end

  logic [AW:0]   w_a_cnt;
  logic [WW+1:0] w_w_sum;
  logic [AW+1:0] w_a_sum;
  logic [CW:0]   w_c_inc;
  logic [KW:0]   w_k_inc;
  logic [LW:0]   w_layer_inc;
  logic          w_w_last, w_a_last, w_c_last, w_k_last, w_layer_last, w_need_input;

  assign w_a_cnt      = r_cfg_sp[r_layer] ? nz_cnt : r_cfg_a[r_layer];
  assign w_w_sum      = {2'b00, r_w} + (WW+2)'(F_STEP);
  assign w_a_sum      = {2'b00, r_a} + (AW+2)'(I_STEP);
  assign w_c_inc      = {1'b0, r_c} + (CW+1)'(1);
  assign w_k_inc      = {1'b0, r_k} + (KW+1)'(1);
  assign w_layer_inc  = {1'b0, r_layer} + (LW+1)'(1);
  assign w_w_last     = w_w_sum >= {1'b0, r_cfg_w[r_layer]};
  assign w_a_last     = w_a_sum >= {1'b0, w_a_cnt};
  assign w_c_last     = w_c_inc >= r_cfg_c[r_layer];
  assign w_k_last     = w_k_inc >= r_cfg_k[r_layer];
  assign w_layer_last = w_layer_inc >= r_num_layers;
  assign w_need_input = (r_layer == '0) && (r_k == '0);

  assign busy      = (r_state != S_IDLE);
  assign cur_c     = r_c;
  assign req_k     = r_k;
  assign req_layer = r_layer;
  assign issue_k   = r_k;
  assign issue_c   = r_c;
  assign issue_a   = r_a;
  assign issue_w   = r_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_layer      <= '0;
      r_k          <= '0;
      r_c          <= '0;
      r_a          <= '0;
      r_w          <= '0;
      r_num_layers <= '0;
      r_fdone      <= 1'b0;
      r_idone      <= 1'b0;
      r_drain      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_layer      <= w_layer_nxt;
      r_k          <= w_k_nxt;
      r_c          <= w_c_nxt;
      r_a          <= w_a_nxt;
      r_w          <= w_w_nxt;
      r_num_layers <= w_nl_nxt;
      r_fdone      <= w_fdone_nxt;
      r_idone      <= w_idone_nxt;
      r_drain      <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_layer_nxt      = r_layer;
    w_k_nxt          = r_k;
    w_c_nxt          = r_c;
    w_a_nxt          = r_a;
    w_w_nxt          = r_w;
    w_nl_nxt         = r_num_layers;
    w_fdone_nxt      = r_fdone;
    w_idone_nxt      = r_idone;
    w_drain_nxt      = r_drain;
    req_filter_valid = 1'b0;
    req_input_valid  = 1'b0;
    issue_valid      = 1'b0;
    issue_last       = 1'b0;
    ppu_start        = 1'b0;
    done             = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_layers != '0) begin
            w_state_nxt = S_STREAM;
            w_nl_nxt    = num_layers;
            w_layer_nxt = '0;
            w_k_nxt     = '0;
            w_c_nxt     = '0;
            w_a_nxt     = '0;
            w_w_nxt     = '0;
          end else begin
            done = 1'b1;
          end
        end
      end
      S_STREAM: begin
        req_filter_valid = !r_fdone;
        req_input_valid  = w_need_input && !r_idone;
        w_fdone_nxt      = r_fdone | filter_done;
        w_idone_nxt      = r_idone | input_done;
        if (r_fdone && (r_idone || !w_need_input)) begin
          w_state_nxt = S_EXEC;
          w_fdone_nxt = 1'b0;
          w_idone_nxt = 1'b0;
          w_c_nxt     = '0;
          w_a_nxt     = '0;
          w_w_nxt     = '0;
        end
      end
      S_EXEC: begin
        // Empty channel (sparse nz_cnt=0) costs one idle cycle and no issue.
        if (w_a_cnt == '0) begin
          w_a_nxt = '0;
          w_w_nxt = '0;
          if (w_c_last) begin
            w_state_nxt = S_DRAIN;
            w_drain_nxt = '0;
          end else begin
            w_c_nxt = w_c_inc[CW-1:0];
          end
        end else begin
          issue_valid = 1'b1;
          issue_last  = w_w_last && w_a_last && w_c_last;
          if (issue_ready) begin
            if (!w_w_last) begin
              w_w_nxt = w_w_sum[WW-1:0];
            end else begin
              w_w_nxt = '0;
              if (!w_a_last) begin
                w_a_nxt = w_a_sum[AW-1:0];
              end else begin
                w_a_nxt = '0;
                if (w_c_last) begin
                  w_state_nxt = S_DRAIN;
                  w_drain_nxt = '0;
                end else begin
                  w_c_nxt = w_c_inc[CW-1:0];
                end
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (r_drain == DW'(PIPE_DEPTH - 1)) begin
          ppu_start   = 1'b1;
          w_state_nxt = S_PPU;
        end else begin
          w_drain_nxt = r_drain + DW'(1);
        end
      end
      S_PPU: begin
        if (ppu_done) begin
          if (!w_k_last) begin
            w_k_nxt     = w_k_inc[KW-1:0];
            w_state_nxt = S_STREAM;
          end else if (!w_layer_last) begin
            w_k_nxt     = '0;
            w_layer_nxt = w_layer_inc[LW-1:0];
            w_state_nxt = S_STREAM;
          end else begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_pe_loop_cntl.sv
// tb/tb_pe_loop_cntl.sv - directed bench for pe_loop_cntl with coordinate scoreboard
module tb_pe_loop_cntl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_layer = '0;
  logic [6:0] cfg_k_cnt = '0;
  logic [6:0] cfg_c_cnt = '0;
  logic [8:0] cfg_a_cnt = '0;
  logic [8:0] cfg_w_cnt = '0;
  logic       cfg_sparse = 1'b0;
  logic [2:0] num_layers = '0;
  logic       start = 1'b0;
  logic [5:0] cur_c;
  logic [8:0] nz_cnt;
  logic       req_filter_valid, req_input_valid;
  logic [5:0] req_k;
  logic [1:0] req_layer;
  logic       filter_done = 1'b0;
  logic       input_done = 1'b0;
  logic       issue_valid;
  logic       issue_ready = 1'b1;
  logic [5:0] issue_k, issue_c;
  logic [7:0] issue_a, issue_w;
  logic       issue_last, ppu_start;
  logic       ppu_done = 1'b0;
  logic       busy, done;

  logic [8:0] nz_tbl [64];
  assign nz_cnt = nz_tbl[cur_c];

  pe_loop_cntl dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
    .cfg_k_cnt(cfg_k_cnt), .cfg_c_cnt(cfg_c_cnt), .cfg_a_cnt(cfg_a_cnt),
    .cfg_w_cnt(cfg_w_cnt), .cfg_sparse(cfg_sparse), .num_layers(num_layers),
    .start(start), .cur_c(cur_c), .nz_cnt(nz_cnt),
    .req_filter_valid(req_filter_valid), .req_input_valid(req_input_valid),
    .req_k(req_k), .req_layer(req_layer), .filter_done(filter_done),
    .input_done(input_done), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_k(issue_k), .issue_c(issue_c), .issue_a(issue_a), .issue_w(issue_w),
    .issue_last(issue_last), .ppu_start(ppu_start), .ppu_done(ppu_done),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [48:0] outs;
  assign outs = {busy, done, issue_valid, issue_last, req_filter_valid, req_input_valid,
                 ppu_start, issue_k, issue_c, issue_a, issue_w, cur_c, req_k, req_layer};

  int checks = 0;
  int errors = 0;
  logic [28:0] exp_q [$];
  logic [7:0]  tag_q [$];
  logic [28:0] mon_e;
  int cyc = 0, last_issue_cyc = 0, ppu_lat = 0;
  int ppu_cnt = 0, done_cnt = 0, in_cnt = 0, issue_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int l, input int k, input int c, input int a, input int w, input bit sp);
    cfg_we = 1'b1; cfg_layer = 2'(l); cfg_k_cnt = 7'(k); cfg_c_cnt = 7'(c);
    cfg_a_cnt = 9'(a); cfg_w_cnt = 9'(w); cfg_sparse = sp;
    step();
    cfg_we = 1'b0;
  endtask

  // Reference loop nest: expected {last,k,c,a,w} for one layer.
  task automatic model(input int nk, input int nc, input int na, input int nw, input bit sp);
    for (int k = 0; k < nk; k++)
      for (int c = 0; c < nc; c++) begin
        int ac = sp ? int'(nz_tbl[c]) : na;
        if (ac == 0) continue;
        for (int a = 0; ; a += 4) begin
          for (int w = 0; ; w += 4) begin
            bit wl = (w + 4 >= nw);
            bit al = (a + 4 >= ac);
            exp_q.push_back({wl && al && (c == nc - 1), 6'(k), 6'(c), 8'(a), 8'(w)});
            if (wl) break;
          end
          if (a + 4 >= ac) break;
        end
      end
  endtask

  task automatic start_run(input int nl);
    start = 1'b1; num_layers = 3'(nl);
    step();
    start = 1'b0;
  endtask

  // Plays stream sources and PPU until done (or until stop_issues accepted issues).
  task automatic run(input bit stall, input int stop_issues, input int budget);
    int n = 0;
    int d0 = done_cnt;
    bit pend = 1'b0;
    while (done_cnt == d0 && n < budget && !(stop_issues > 0 && issue_cnt >= stop_issues)) begin
      filter_done = req_filter_valid;
      input_done  = req_input_valid;
      if (req_filter_valid) tag_q.push_back({req_layer, req_k});
      if (req_input_valid) in_cnt++;
      ppu_done = pend;
      pend = ppu_start;
      issue_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    filter_done = 1'b0; input_done = 1'b0; ppu_done = 1'b0; issue_ready = 1'b1;
    chk("run_timeout", 64'(n < budget), 64'(1));
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      cyc++;
      if (issue_valid && issue_ready) begin
        issue_cnt++;
        last_issue_cyc = cyc;
        if (exp_q.size() == 0) chk("issue_extra", 64'(exp_q.size()), 64'(1));
        else begin
          mon_e = exp_q.pop_front();
          chk("issue", 64'({issue_last, issue_k, issue_c, issue_a, issue_w}), 64'(mon_e));
        end
      end
      if (ppu_start) begin
        ppu_cnt++;
        ppu_lat = cyc - last_issue_cyc;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    int i0, p0, d0, in0;
    logic [7:0] t;
    for (int i = 0; i < 64; i++) nz_tbl[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 64'(outs), 64'(0));
    rst_n = 1'b1;
    step();
    chk("idle_outs", 64'(outs), 64'(0));

    // num_layers=0: immediate done, stays idle
    start = 1'b1; num_layers = 3'd0;
    #1;
    chk("nl0_done", 64'(done), 64'(1));
    step();
    start = 1'b0;
    chk("nl0_idle", 64'(busy), 64'(0));

    // Dense single layer, 4 issues
    cfg(0, 1, 1, 8, 8, 1'b0);
    model(1, 1, 8, 8, 1'b0);
    p0 = ppu_cnt; i0 = issue_cnt;
    start_run(1);
    run(1'b0, 0, 500);
    chk("dense_empty", 64'(exp_q.size()), 64'(0));
    chk("dense_issues", 64'(issue_cnt - i0), 64'(4));
    chk("dense_ppu_lat", 64'(ppu_lat), 64'(6));
    chk("dense_ppu_cnt", 64'(ppu_cnt - p0), 64'(1));
    chk("dense_idle", 64'(busy), 64'(0));

    // Sparse with an empty middle channel
    nz_tbl[0] = 9'd4; nz_tbl[1] = 9'd0; nz_tbl[2] = 9'd8;
    cfg(0, 1, 3, 200, 4, 1'b1);
    model(1, 3, 200, 4, 1'b1);
    i0 = issue_cnt;
    start_run(1);
    run(1'b0, 0, 500);
    chk("sparse_empty", 64'(exp_q.size()), 64'(0));
    chk("sparse_issues", 64'(issue_cnt - i0), 64'(3));

    // 2x2x8x8 without then with random stalls
    cfg(0, 2, 2, 8, 8, 1'b0);
    model(2, 2, 8, 8, 1'b0);
    start_run(1);
    run(1'b0, 0, 500);
    chk("nostall_empty", 64'(exp_q.size()), 64'(0));
    model(2, 2, 8, 8, 1'b0);
    i0 = issue_cnt;
    start_run(1);
    run(1'b1, 0, 2000);
    chk("stall_empty", 64'(exp_q.size()), 64'(0));
    chk("stall_issues", 64'(issue_cnt - i0), 64'(16));

    // Stream flags: filter first, input later
    cfg(0, 1, 1, 4, 4, 1'b0);
    model(1, 1, 4, 4, 1'b0);
    start_run(1);
    chk("req_filter", 64'(req_filter_valid), 64'(1));
    chk("req_input", 64'(req_input_valid), 64'(1));
    filter_done = 1'b1;
    step();
    filter_done = 1'b0;
    chk("req_filter_drop", 64'(req_filter_valid), 64'(0));
    step();
    step();
    chk("wait_input", 64'(issue_valid), 64'(0));
    input_done = 1'b1;
    step();
    input_done = 1'b0;
    chk("flag_cycle", 64'(issue_valid), 64'(0));
    step();
    chk("exec_entry", 64'(issue_valid), 64'(1));
    run(1'b0, 0, 500);
    chk("order_empty", 64'(exp_q.size()), 64'(0));

    // Stream flags: both in the same cycle
    model(1, 1, 4, 4, 1'b0);
    start_run(1);
    filter_done = 1'b1; input_done = 1'b1;
    step();
    filter_done = 1'b0; input_done = 1'b0;
    chk("both_flag_cycle", 64'(issue_valid), 64'(0));
    step();
    chk("both_exec_entry", 64'(issue_valid), 64'(1));
    run(1'b0, 0, 500);
    chk("both_empty", 64'(exp_q.size()), 64'(0));

    // Two layers, two k groups each
    cfg(0, 2, 1, 4, 4, 1'b0);
    cfg(1, 2, 1, 4, 4, 1'b0);
    model(2, 1, 4, 4, 1'b0);
    model(2, 1, 4, 4, 1'b0);
    tag_q.delete();
    in0 = in_cnt; p0 = ppu_cnt; d0 = done_cnt;
    start_run(2);
    run(1'b0, 0, 1000);
    chk("ml_tag_cnt", 64'(tag_q.size()), 64'(4));
    for (int l = 0; l < 2; l++)
      for (int k = 0; k < 2; k++) begin
        if (tag_q.size() > 0) t = tag_q.pop_front();
        else t = 8'hff;
        chk("ml_req_tag", 64'(t), 64'({2'(l), 6'(k)}));
      end
    chk("ml_input_once", 64'(in_cnt - in0), 64'(1));
    chk("ml_ppu_cnt", 64'(ppu_cnt - p0), 64'(4));
    chk("ml_done_cnt", 64'(done_cnt - d0), 64'(1));
    chk("ml_empty", 64'(exp_q.size()), 64'(0));

    // Reset mid-EXEC; config write while busy must be dropped
    cfg(0, 2, 2, 8, 8, 1'b0);
    model(2, 2, 8, 8, 1'b0);
    start_run(1);
    run(1'b0, issue_cnt + 5, 500);
    cfg(0, 5, 1, 4, 4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", 64'(outs), 64'(0));
    step();
    chk("midrst_hold", 64'(outs), 64'(0));
    exp_q.delete();
    rst_n = 1'b1;
    step();
    model(2, 2, 8, 8, 1'b0);
    p0 = ppu_cnt;
    start_run(1);
    run(1'b1, 0, 2000);
    chk("rerun_empty", 64'(exp_q.size()), 64'(0));
    chk("rerun_ppu_cnt", 64'(ppu_cnt - p0), 64'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
